// File: rtl/input_sram_loader_pkg.sv
// Shared definitions for the input SRAM loader and its header checker.
// Holds the SRAM geometry, legal matrix dimension range, list terminator,
// the loader state encoding and the header word builder.
package input_sram_loader_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int N_MIN  = 4;
  localparam int N_MAX  = 64;

  localparam logic [15:0] TERM_WORD = 16'hFFFF;
  localparam logic [7:0]  HDR_UPPER = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_TERM,
    ST_ERR,
    ST_DONE
  } ld_state_e;

  // Header word is the dimension N with a zero upper byte.
  function automatic logic [15:0] hdr_word(input logic [7:0] n);
    return {HDR_UPPER, n};
  endfunction

endpackage

// File: rtl/input_sram_hdr_check.sv
// Combinational matrix-header checker.
//   n        : header byte (matrix dimension, unsigned)
//   hdr_addr : address where this header would be written
//   n_ok     : N is even and within [N_MIN, N_MAX]
//   fits     : header + N*N/2 data words still leave room for the terminator
//   words    : N*N/2, the data word count of the matrix (valid when n_ok)
module input_sram_hdr_check
  import input_sram_loader_pkg::*;
#(
  parameter int ADDR_W_P = ADDR_W,
  parameter int N_MIN_P  = N_MIN,
  parameter int N_MAX_P  = N_MAX
) (
  input  logic [7:0]          n,
  input  logic [ADDR_W_P-1:0] hdr_addr,
  output logic                n_ok,
  output logic                fits,
  output logic [ADDR_W_P-1:0] words
);

  // Wide enough that hdr_addr + 1 + 255*255/2 can never wrap.
  localparam int EW = ADDR_W_P + 17;
  localparam logic [EW-1:0] LIMIT = EW'((64'd1 << ADDR_W_P) - 64'd1);
  localparam logic [7:0]    NMIN8 = 8'(N_MIN_P);
  localparam logic [7:0]    NMAX8 = 8'(N_MAX_P);

  logic [15:0]   sq;
  logic [EW-1:0] end_addr;

  always_comb begin
    sq       = 16'(n) * 16'(n);
    words    = ADDR_W_P'(sq >> 1);
    n_ok     = !n[0] && (n >= NMIN8) && (n <= NMAX8);
    end_addr = EW'(hdr_addr) + EW'(1) + EW'(sq >> 1);
    fits     = (end_addr <= LIMIT);
  end

endmodule

// File: rtl/input_sram_loader.sv
// Byte-stream front end for the engine's input SRAM. Accepts square matrices
// (header byte N followed by N*N element bytes) over valid/ready, packs two
// bytes per word (earlier byte in the upper half), writes header + data words
// from address 0 and closes the list with TERM_WORD. A malformed header or a
// misplaced last flag rewinds the terminator to the current header address so
// the list keeps only complete matrices.
//   clk, reset_b        : clock, synchronous active-high reset
//   load_start          : begin a session (IDLE only)
//   s_valid/s_ready/s_data/s_last_set : byte stream in
//   input_sram_write_*  : registered SRAM write port
//   load_busy/load_done/load_error    : session status
module input_sram_loader
  import input_sram_loader_pkg::*;
#(
  parameter int                ADDR_W_P    = ADDR_W,
  parameter int                DATA_W_P    = DATA_W,
  parameter int                N_MIN_P     = N_MIN,
  parameter int                N_MAX_P     = N_MAX,
  parameter logic [DATA_W_P-1:0] TERM_WORD_P = DATA_W_P'(TERM_WORD)
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                load_start,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [7:0]          s_data,
  input  logic                s_last_set,
  output logic                input_sram_write_enable,
  output logic [ADDR_W_P-1:0] input_sram_write_addresss,
  output logic [DATA_W_P-1:0] input_sram_write_data,
  output logic                load_busy,
  output logic                load_done,
  output logic                load_error
);

  ld_state_e state, state_d;
  logic [ADDR_W_P-1:0] addr, addr_d, hdr_addr, hdr_d, remaining, rem_d, words;
  logic [7:0]          hi, hi_d;
  logic                err_d, we_d, xfer, n_ok, fits;
  logic [ADDR_W_P-1:0] waddr_d;
  logic [DATA_W_P-1:0] wdata_d;

  input_sram_hdr_check #(
    .ADDR_W_P(ADDR_W_P),
    .N_MIN_P (N_MIN_P),
    .N_MAX_P (N_MAX_P)
  ) u_hdr_check (
    .n       (s_data),
    .hdr_addr(hdr_addr),
    .n_ok    (n_ok),
    .fits    (fits),
    .words   (words)
  );

  // Status and ready are pure state decodes.
  always_comb begin
    s_ready   = (state == ST_HDR) || (state == ST_DATA_HI) || (state == ST_DATA_LO);
    load_busy = (state != ST_IDLE) && (state != ST_DONE);
    load_done = (state == ST_DONE);
  end

  assign xfer = s_valid & s_ready;

  always_comb begin
    state_d = state;
    addr_d  = addr;
    hdr_d   = hdr_addr;
    rem_d   = remaining;
    hi_d    = hi;
    err_d   = load_error;
    we_d    = 1'b0;
    waddr_d = addr;
    wdata_d = TERM_WORD_P;
    case (state)
      ST_IDLE: if (load_start) begin
        state_d = ST_HDR;
        addr_d  = '0;
        hdr_d   = '0;
        err_d   = 1'b0;
      end
      ST_HDR: if (xfer) begin
        if (n_ok && fits) begin
          we_d    = 1'b1;
          wdata_d = DATA_W_P'(hdr_word(s_data));
          addr_d  = addr + 1'b1;
          rem_d   = words;
          state_d = ST_DATA_HI;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_DATA_HI: if (xfer) begin
        if (s_last_set) state_d = ST_ERR;
        else begin
          hi_d    = s_data;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: if (xfer) begin
        we_d    = 1'b1;
        wdata_d = DATA_W_P'({hi, s_data});
        addr_d  = addr + 1'b1;
        rem_d   = remaining - 1'b1;
        if (remaining == ADDR_W_P'(1)) begin
          if (s_last_set) state_d = ST_TERM;
          else begin
            hdr_d   = addr + 1'b1;  // next header lands right after this word
            state_d = ST_HDR;
          end
        end else begin
          state_d = s_last_set ? ST_ERR : ST_DATA_HI;
        end
      end
      ST_TERM: begin
        we_d    = 1'b1;
        state_d = ST_DONE;
      end
      ST_ERR: begin
        // Overwrite the bad header slot so the list ends at the last good matrix.
        we_d    = 1'b1;
        waddr_d = hdr_addr;
        err_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      state                     <= ST_IDLE;
      addr                      <= '0;
      hdr_addr                  <= '0;
      remaining                 <= '0;
      hi                        <= '0;
      load_error                <= 1'b0;
      input_sram_write_enable   <= 1'b0;
      input_sram_write_addresss <= '0;
      input_sram_write_data     <= '0;
    end else begin
      state                     <= state_d;
      addr                      <= addr_d;
      hdr_addr                  <= hdr_d;
      remaining                 <= rem_d;
      hi                        <= hi_d;
      load_error                <= err_d;
      input_sram_write_enable   <= we_d;
      input_sram_write_addresss <= waddr_d;
      input_sram_write_data     <= wdata_d;
    end
  end

endmodule

// File: tb/tb_input_sram_loader.sv
// Randomized self-checking bench for input_sram_loader. Each session's byte
// stream is interpreted by a stream-level reference model that produces the
// expected SRAM write list, error flag and done pulse count.
module tb_input_sram_loader;

  logic        clk = 1'b0;
  logic        reset_b, load_start, s_valid, s_last_set;
  logic [7:0]  s_data;
  logic        s_ready, we, load_busy, load_done, load_error;
  logic [11:0] waddr;
  logic [15:0] wdata;

  input_sram_loader dut (
    .clk                      (clk),
    .reset_b                  (reset_b),
    .load_start               (load_start),
    .s_valid                  (s_valid),
    .s_ready                  (s_ready),
    .s_data                   (s_data),
    .s_last_set               (s_last_set),
    .input_sram_write_enable  (we),
    .input_sram_write_addresss(waddr),
    .input_sram_write_data    (wdata),
    .load_busy                (load_busy),
    .load_done                (load_done),
    .load_error               (load_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [27:0] got_q[$], exp_q[$];
  logic [7:0]  stim_b[$];
  bit          stim_l[$];
  int          done_cnt = 0;
  bit          exp_err, exp_done, stray;
  int          maxgap;

  // Write / done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (we) got_q.push_back({waddr, wdata});
    if (load_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic add_hdr(input int n);
    stim_b.push_back(8'(n));
    stim_l.push_back(1'b0);
  endtask

  task automatic add_mat(input int n, input bit last_end, input bit seq);
    add_hdr(n);
    for (int i = 0; i < n * n; i++) begin
      stim_b.push_back(seq ? 8'(i + 1) : 8'($urandom));
      stim_l.push_back(last_end && (i == n * n - 1));
    end
  endtask

  // Reference: walk the stream matrix by matrix and list the words the SRAM
  // should receive. A stream that simply runs out produces no terminator.
  task automatic model();
    int p = 0, addr = 0, hdr = 0, n, words;
    int nb = stim_b.size();
    bit stop = 0;
    exp_q.delete();
    exp_err = 0;
    exp_done = 0;
    while (!stop && p < nb) begin
      n = int'(stim_b[p]);
      p++;
      hdr = addr;
      if ((n % 2) != 0 || n < 4 || n > 64 || hdr + 1 + n * n / 2 > 4095) begin
        exp_q.push_back({12'(hdr), 16'hFFFF});
        exp_err = 1; exp_done = 1; stop = 1;
      end else begin
        exp_q.push_back({12'(addr), 16'(n)});
        addr++;
        words = n * n / 2;
        for (int k = 0; k < words && !stop; k++) begin
          if (p >= nb) begin stop = 1; break; end
          if (stim_l[p]) begin
            exp_q.push_back({12'(hdr), 16'hFFFF});
            exp_err = 1; exp_done = 1; stop = 1; break;
          end
          if (p + 1 >= nb) begin stop = 1; break; end
          exp_q.push_back({12'(addr), stim_b[p], stim_b[p + 1]});
          addr++;
          p += 2;
          if (stim_l[p - 1]) begin
            stop = 1; exp_done = 1;
            if (k == words - 1) exp_q.push_back({12'(addr), 16'hFFFF});
            else begin
              exp_q.push_back({12'(hdr), 16'hFFFF});
              exp_err = 1;
            end
          end
        end
      end
    end
  endtask

  // Present one byte (after an optional idle gap) and hold it until taken.
  // Returns ok=0 if the session ended before the byte was accepted.
  task automatic send(input logic [7:0] b, input bit last, output bit ok);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    s_valid = 1'b0;
    repeat (g) @(negedge clk);
    s_valid = 1'b1; s_data = b; s_last_set = last;
    if (stray && load_busy && $urandom_range(0, 5) == 0) load_start = 1'b1;
    ok = 0;
    for (int t = 0; t < 64; t++) begin
      if (s_ready) begin
        ok = 1;
        @(negedge clk);
        load_start = 1'b0;
        break;
      end
      if (!load_busy) break;
      @(negedge clk);
      load_start = 1'b0;
    end
    load_start = 1'b0; s_valid = 1'b0; s_last_set = 1'b0;
    if (!ok && load_busy) chk("hs_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare(input string tag, input int g0, input int d0);
    chk({tag, "_nwr"}, got_q.size() - g0, exp_q.size());
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), got_q[g0 + i], exp_q[i]);
    chk({tag, "_done"}, done_cnt - d0, exp_done ? 1 : 0);
  endtask

  task automatic run_session(input string tag);
    int g0, d0;
    bit ok;
    g0 = got_q.size();
    d0 = done_cnt;
    model();
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    for (int i = 0; i < stim_b.size(); i++) begin
      send(stim_b[i], stim_l[i], ok);
      if (!ok) break;
    end
    for (int t = 0; t < 20 && done_cnt == d0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    compare(tag, g0, d0);
    chk({tag, "_err"}, load_error, exp_err);
    chk({tag, "_rdy"}, s_ready, 0);
    chk({tag, "_busy"}, load_busy, 0);
    stim_b.delete();
    stim_l.delete();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g0, d0, bad[5];
    bit ok;
    bad = '{3, 5, 2, 70, 0};
    reset_b = 1'b1; load_start = 1'b0; s_valid = 1'b0; s_last_set = 1'b0; s_data = 8'h00;
    maxgap = 0; stray = 0;
    repeat (3) @(negedge clk);
    chk("rst_we", we, 0);
    chk("rst_addr", waddr, 0);
    chk("rst_data", wdata, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_error, 0);
    chk("rst_rdy", s_ready, 0);
    reset_b = 1'b0;
    @(negedge clk);

    add_mat(4, 1, 1);
    run_session("n4_seq");
    chk("n4_seq_term", got_q[got_q.size() - 1], {12'd9, 16'hFFFF});

    add_mat(4, 0, 0); add_mat(6, 1, 0);
    run_session("n4_n6");

    maxgap = 5;
    add_mat(4, 1, 1);
    run_session("n4_gaps");
    maxgap = 0;

    add_hdr(5);  run_session("bad_n5");
    add_hdr(66); run_session("bad_n66");

    add_mat(64, 0, 0); add_mat(64, 1, 0);
    run_session("n64_ovf");

    add_mat(4, 0, 1);
    stim_l[10] = 1'b1;
    run_session("early_last");

    // Reset in the middle of a matrix: header + 3 words, then nothing.
    add_mat(4, 1, 1);
    while (stim_b.size() > 7) begin
      void'(stim_b.pop_back());
      void'(stim_l.pop_back());
    end
    g0 = got_q.size(); d0 = done_cnt;
    model();
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    for (int i = 0; i < stim_b.size(); i++) send(stim_b[i], stim_l[i], ok);
    reset_b = 1'b1;
    @(negedge clk);
    chk("mid_rst_we", we, 0);
    chk("mid_rst_busy", load_busy, 0);
    chk("mid_rst_err", load_error, 0);
    chk("mid_rst_rdy", s_ready, 0);
    reset_b = 1'b0;
    repeat (5) @(negedge clk);
    compare("mid_rst", g0, d0);
    stim_b.delete(); stim_l.delete();

    add_mat(4, 1, 1);
    run_session("after_rst");

    // Randomized sessions with gaps and stray load_start pulses mid-session.
    stray = 1;
    for (int r = 0; r < 8; r++) begin
      int nm;
      maxgap = $urandom_range(0, 3);
      nm = $urandom_range(1, 3);
      for (int m = 0; m < nm; m++) begin
        if ($urandom_range(0, 5) == 0) begin
          add_hdr(bad[$urandom_range(0, 4)]);
          break;
        end
        add_mat(2 * $urandom_range(2, 5), m == nm - 1, 0);
      end
      if ($urandom_range(0, 3) == 0 && stim_b.size() > 3) begin
        int li;
        li = $urandom_range(1, stim_b.size() - 1);
        foreach (stim_l[i]) stim_l[i] = 1'b0;
        stim_l[li] = 1'b1;
      end
      run_session($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
